param_lock: RTL
===============

# param_lock

Parametrised successor to the team's fixed four-digit combination lock. Collects a keyed code one digit per strobe, compares it against a programmable code register, and drives the unlock output. Counts consecutive failures and enforces a timed lockout with buzzer. While unlocked, supports re-programming the code. Sits between the keypad decoder and the door actuator/buzzer drivers.

## Interface

- `DIGIT_W`, 4, bits per keyed digit
- `CODE_LEN`, 4, digits per code (≥1)
- `MAX_TRIES`, 3, consecutive wrong codes before lockout (≥1)
- `LOCKOUT_CYC`, 16, lockout duration in clk cycles (≥1)
- `DEFAULT_CODE`, 16'hABFD, reset code, `CODE_LEN*DIGIT_W` bits; digit 0 is the MS digit

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `digit`  in  DIGIT_W  keyed digit, sampled only when `digit_valid`=1
- `digit_valid`  in  1  one-cycle strobe; one digit per high cycle
- `start`  in  1  begin or restart entry
- `prog`  in  1  request code change (UNLOCKED only)
- `relock`  in  1  return to locked idle
- `out`  out  1  unlocked indicator
- `buzzer`  out  1  alarm
- `locked_out`  out  1  lockout active
- `fail_count`  out  clog2(MAX_TRIES+1)  consecutive failures
- `pos`  out  clog2(CODE_LEN+1)  digits entered in the current entry/program sequence

## Operation

- **Reset (async, `reset`=0):**
  - state IDLE; code register = DEFAULT_CODE.
  - `out`, `buzzer`, `locked_out`, `fail_count`, `pos` all 0.
- **IDLE:**
  - `start` → ENTRY, `pos`=0.
  - `digit_valid`, `prog`, `relock` ignored.
- **ENTRY:**
  - `start` has priority: `pos`=0, partial entry discarded, even if `digit_valid` is high in the same cycle.
  - Otherwise `digit_valid` stores `digit` at index `pos`, then `pos`++.
  - On the CODE_LEN-th digit, the full entry (including that digit) is compared with the code register.
  - Match → UNLOCKED; `fail_count`=0; `pos`=0.
  - Mismatch with `fail_count`+1 < MAX_TRIES → IDLE; `fail_count`++; one-cycle `buzzer` pulse.
  - Mismatch with `fail_count`+1 = MAX_TRIES → LOCKOUT; `fail_count`=MAX_TRIES (saturates); lockout timer loaded.
- **UNLOCKED:**
  - `out`=1.
  - `relock` → IDLE; it wins over `prog` in the same cycle.
  - `prog` → PROGRAM, `pos`=0.
- **PROGRAM:**
  - `out` stays 1; `digit_valid` fills a shadow register.
  - After the CODE_LEN-th digit, the code register updates atomically from the shadow; state → UNLOCKED.
  - `relock` aborts: code unchanged, → IDLE.
  - `start` is ignored.
- **LOCKOUT:**
  - `buzzer`=1 and `locked_out`=1 continuously.
  - All inputs ignored.
  - After LOCKOUT_CYC cycles → IDLE with `fail_count`=0.
- **Reset mid-operation:** reset in any state, including PROGRAM and LOCKOUT, restores DEFAULT_CODE and clears all counters.

## Timing

- All outputs are registered; no combinational input→output paths.
- Digit accepted on cycle N → `pos` updates on N+1.
- Correct final digit on N → `out`=1 on N+1.
- Wrong final digit on N → `buzzer`=1 on N+1:
  - exactly one cycle for a non-lockout failure;
  - exactly LOCKOUT_CYC cycles (N+1 … N+LOCKOUT_CYC) for the lockout failure.
- Lockout exit: `locked_out` and `buzzer` fall on N+LOCKOUT_CYC+1, when the state returns to IDLE. A `start` on that cycle is honoured.
- `relock` on cycle M → `out`=0 on M+1.
- New code is usable for any entry starting after its final program digit.
- Lockout counter: clog2(LOCKOUT_CYC+1) bits, down-counting, no wrap.

## Structure

- Package `lock_pkg`:
  - state encoding (IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT);
  - width helper constants for `pos`, `fail_count` and the timer.
- Sub-module `lock_timer`:
  - loadable down-counter with a `done` flag;
  - used for the lockout period.
- FSM, entry/shadow shift registers and comparator live in `param_lock`.
- Parameter legality (CODE_LEN, MAX_TRIES, LOCKOUT_CYC ≥ 1) is checked at elaboration.

## Test plan

All scenarios use default parameters.

1. **Correct code:** `start`, then digits A,B,F,D → `out`=1 one cycle after D; `fail_count`=0; `pos`=0.
2. **Single failure:** `start`, then A,B,F,C → one-cycle `buzzer` pulse; `fail_count`=1; state IDLE; `out`=0.
3. **Lockout:** three wrong codes →
   - `locked_out`=1 and `buzzer`=1 for exactly 16 cycles;
   - a keyed A,B,F,D during lockout is ignored;
   - afterwards `fail_count`=0, and a correct code then unlocks.
4. **Restart mid-entry:** `start`, A,B, then `start` together with `digit_valid` (F), then A,B,F,D → unlocks; the F was discarded.
5. **Reprogram:** unlock, `prog`, digits 1,2,3,4 → `out` stays 1.
   - `relock`, then A,B,F,D → fail.
   - 1,2,3,4 → unlock.
   - `relock` mid-PROGRAM leaves the code unchanged.
6. **Async reset:** assert `reset` low mid-LOCKOUT and mid-PROGRAM, between clock edges → all outputs 0 immediately; code reverts to ABFD.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encoding and width helpers for the parametrised combination lock.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_UNLOCKED,
        ST_PROGRAM,
        ST_LOCKOUT
    } state_t;

    // Bits needed to hold the values 0..n inclusive (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that parks at zero; o_done flags the zero state.
module lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/param_lock.sv
// Programmable N-digit combination lock with failure counting, timed lockout
// and in-place code re-programming while unlocked.
module param_lock
    import lock_pkg::*;
#(
    parameter int                             DIGIT_W      = 4,
    parameter int                             CODE_LEN     = 4,
    parameter int                             MAX_TRIES    = 3,
    parameter int                             LOCKOUT_CYC  = 16,
    parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE = 16'hABFD
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               digit_valid,
    input  logic                               start,
    input  logic                               prog,
    input  logic                               relock,
    output logic                               out,
    output logic                               buzzer,
    output logic                               locked_out,
    output logic [cnt_w(MAX_TRIES)-1:0]        fail_count,
    output logic [cnt_w(CODE_LEN)-1:0]         pos
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int POS_W  = cnt_w(CODE_LEN);
    localparam int FAIL_W = cnt_w(MAX_TRIES);
    localparam int TMR_W  = cnt_w(LOCKOUT_CYC);

    if (CODE_LEN < 1 || MAX_TRIES < 1 || LOCKOUT_CYC < 1) begin : g_bad_param
        $error("param_lock: CODE_LEN, MAX_TRIES and LOCKOUT_CYC must all be >= 1");
    end

    state_t              r_state, w_nxt;
    logic [POS_W-1:0]    r_pos, w_pos_n;
    logic [FAIL_W-1:0]   r_fail, w_fail_n;
    logic [CODE_W-1:0]   r_entry, r_shadow, r_code;
    logic [CODE_W-1:0]   w_entry_cand, w_shadow_cand;
    logic                r_out, r_buzz, r_lo;
    logic                w_buzz_n, w_shift_e, w_shift_s, w_code_we, w_load, w_tmr_done;
    logic                w_last;

    // Digits shift in at the LS end, so after CODE_LEN strobes digit 0 sits MS.
    assign w_entry_cand  = CODE_W'({r_entry, digit});
    assign w_shadow_cand = CODE_W'({r_shadow, digit});
    assign w_last        = (r_pos == POS_W'(CODE_LEN - 1));

    // Loaded with LOCKOUT_CYC-1 so done rises on the last lockout cycle.
    lock_timer #(.W(TMR_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_val  (TMR_W'(LOCKOUT_CYC - 1)),
        .o_done (w_tmr_done)
    );

    always_comb begin
        w_nxt     = r_state;
        w_pos_n   = r_pos;
        w_fail_n  = r_fail;
        w_buzz_n  = 1'b0;
        w_shift_e = 1'b0;
        w_shift_s = 1'b0;
        w_code_we = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt   = ST_ENTRY;
                    w_pos_n = '0;
                end
            end
            ST_ENTRY: begin
                if (start) begin
                    w_pos_n = '0;
                end else if (digit_valid) begin
                    w_shift_e = 1'b1;
                    if (!w_last) begin
                        w_pos_n = r_pos + POS_W'(1);
                    end else begin
                        w_pos_n = '0;
                        if (w_entry_cand == r_code) begin
                            w_nxt    = ST_UNLOCKED;
                            w_fail_n = '0;
                        end else if (int'(r_fail) + 1 < MAX_TRIES) begin
                            w_nxt    = ST_IDLE;
                            w_fail_n = r_fail + FAIL_W'(1);
                            w_buzz_n = 1'b1;
                        end else begin
                            w_nxt    = ST_LOCKOUT;
                            w_fail_n = FAIL_W'(MAX_TRIES);
                            w_buzz_n = 1'b1;
                            w_load   = 1'b1;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                if (relock) begin
                    w_nxt = ST_IDLE;
                end else if (prog) begin
                    w_nxt   = ST_PROGRAM;
                    w_pos_n = '0;
                end
            end
            ST_PROGRAM: begin
                if (relock) begin
                    w_nxt   = ST_IDLE;
                    w_pos_n = '0;
                end else if (digit_valid) begin
                    w_shift_s = 1'b1;
                    if (w_last) begin
                        w_code_we = 1'b1;
                        w_nxt     = ST_UNLOCKED;
                        w_pos_n   = '0;
                    end else begin
                        w_pos_n = r_pos + POS_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (w_tmr_done) begin
                    w_nxt    = ST_IDLE;
                    w_fail_n = '0;
                end else begin
                    w_buzz_n = 1'b1;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_pos    <= '0;
            r_fail   <= '0;
            r_entry  <= '0;
            r_shadow <= '0;
            r_code   <= DEFAULT_CODE;
            r_out    <= 1'b0;
            r_buzz   <= 1'b0;
            r_lo     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_pos   <= w_pos_n;
            r_fail  <= w_fail_n;
            r_buzz  <= w_buzz_n;
            r_out   <= (w_nxt == ST_UNLOCKED) || (w_nxt == ST_PROGRAM);
            r_lo    <= (w_nxt == ST_LOCKOUT);
            if (w_shift_e) r_entry  <= w_entry_cand;
            if (w_shift_s) r_shadow <= w_shadow_cand;
            if (w_code_we) r_code   <= w_shadow_cand;
        end
    end

    assign out        = r_out;
    assign buzzer     = r_buzz;
    assign locked_out = r_lo;
    assign fail_count = r_fail;
    assign pos        = r_pos;

endmodule
